tick_timer_irq: RTL and testbench

//  Multi-channel event/interrupt timer fed by the prescaled tick of the clock

---
 rtl/tick_timer_irq.sv | 139 +++++++++++++
 tb/tb_tick_timer_irq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_irq.sv
// rtl/tick_timer_irq.sv - multi-channel tick-driven reload timer with sticky status and level irq
// Optional channel cascading (CTRL[3]) is built only when TICK_TIMER_CASCADE_EN is defined.
module tick_timer_irq #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic             cs,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

`ifdef TICK_TIMER_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif

  localparam logic [3:0] ADDR_STAT = 4'd12;
  localparam logic [3:0] ADDR_PEND = 4'd13;
  localparam int C_EN   = 0;
  localparam int C_PER  = 1;
  localparam int C_IE   = 2;
  localparam int C_CASC = 3;

  logic [WIDTH-1:0] reload_q [NCH];
  logic [WIDTH-1:0] reload_d [NCH];
  logic [WIDTH-1:0] count_q  [NCH];
  logic [WIDTH-1:0] count_d  [NCH];
  logic [3:0]       ctrl_q   [NCH];
  logic [3:0]       ctrl_d   [NCH];
  logic [NCH-1:0]   stat_q;
  logic [NCH-1:0]   stat_d;

  logic [3:0]     a;
  logic           wr;
  logic [NCH-1:0] ie;
  logic [NCH-1:0] pend;
  logic           hit_reload;
  logic           hit_count;
  logic           hit_ctrl;
  logic           step;
  logic           expire;
  logic           prev_expire;
  logic           unused_addr;

  assign a           = addr[3:0];
  assign wr          = cs & wen;
  assign unused_addr = ^addr[WIDTH-1:4];

  // Channels are evaluated in order so a cascaded channel sees its
  // predecessor's expiry pulse from the same cycle.
  always_comb begin
    stat_d      = stat_q;
    prev_expire = 1'b0;
    hit_reload  = 1'b0;
    hit_count   = 1'b0;
    hit_ctrl    = 1'b0;
    step        = 1'b0;
    expire      = 1'b0;
    if (wr && a == ADDR_STAT) stat_d = stat_q & ~din[NCH-1:0];
    for (int i = 0; i < NCH; i++) begin
      reload_d[i] = reload_q[i];
      count_d[i]  = count_q[i];
      ctrl_d[i]   = ctrl_q[i];
      hit_reload  = wr && (a == 4'(3 * i));
      hit_count   = wr && (a == 4'(3 * i + 1));
      hit_ctrl    = wr && (a == 4'(3 * i + 2));
      step        = (CASC_EN && i != 0 && ctrl_q[i][C_CASC]) ? prev_expire : tick;
      expire      = 1'b0;
      if (hit_reload) reload_d[i] = din;
      // A bus write to COUNT or CTRL swallows this cycle's step.
      if (hit_ctrl) begin
        ctrl_d[i] = din[3:0] & ((CASC_EN && i != 0) ? 4'hF : 4'h7);
        if (din[C_EN]) count_d[i] = reload_q[i];
      end else if (hit_count) begin
        count_d[i] = din;
      end else if (step && ctrl_q[i][C_EN] && count_q[i] != '0) begin
        if (count_q[i] == WIDTH'(1)) begin
          expire = 1'b1;
          if (ctrl_q[i][C_PER]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i]      = '0;
            ctrl_d[i][C_EN] = 1'b0;
          end
        end else begin
          count_d[i] = count_q[i] - WIDTH'(1);
        end
      end
      // Set after the W1C so a coincident expiry is never lost.
      if (expire) stat_d[i] = 1'b1;
      prev_expire = expire;
    end
  end

  always_comb begin
    ie = '0;
    for (int i = 0; i < NCH; i++) ie[i] = ctrl_q[i][C_IE];
  end

  assign pend = stat_q & ie;
  assign irq  = |pend;

  always_comb begin
    dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (a == 4'(3 * i))          dout = reload_q[i];
      else if (a == 4'(3 * i + 1)) dout = count_q[i];
      else if (a == 4'(3 * i + 2)) dout = WIDTH'(ctrl_q[i]);
    end
    if (a == ADDR_STAT)      dout = WIDTH'(stat_q);
    else if (a == ADDR_PEND) dout = WIDTH'(pend);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        reload_q[i] <= '0;
        count_q[i]  <= '0;
        ctrl_q[i]   <= '0;
      end
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        reload_q[i] <= reload_d[i];
        count_q[i]  <= count_d[i];
        ctrl_q[i]   <= ctrl_d[i];
      end
      stat_q <= stat_d;
    end
  end

endmodule

// File: tb/tb_tick_timer_irq.sv
// tb/tb_tick_timer_irq.sv - scoreboard bench for tick_timer_irq
// Address 16 in the expectation queue stands for the irq pin.
module tb_tick_timer_irq;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [31:0] addr;
  logic [31:0] din;
  logic        wen;
  logic        cs;
  logic [31:0] dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          a;
    logic [31:0] v;
  } exp_t;

  exp_t exp_q[$];

  tick_timer_irq #(.WIDTH(32), .NCH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .addr (addr),
    .din  (din),
    .wen  (wen),
    .cs   (cs),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  function automatic void push(input string n, input int a, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.a    = a;
    e.v    = v;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input logic t, input logic w, input int a, input logic [31:0] d);
    @(negedge clk);
    tick = t; cs = w; wen = w; addr = 32'(a); din = d;
    @(negedge clk);
    tick = 0; cs = 0; wen = 0; din = 0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    if (a == 16) begin
      #1 v = {31'b0, irq};
    end else begin
      addr = 32'(a);
      #1 v = dout;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] got;
    for (int a = 0; a < 16; a++) push("rst_reg", a, 32'h0);
    push("rst_irq", 16, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk); rd(e.a, got);
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s a=%0d got=0x%0h exp=0x%0h", e.name, e.a, got, e.v); end
    end
    @(negedge clk); reset = 1;
    repeat (2) cyc(0, 0, 0, 0);
    push("rel_irq", 16, 32'h0);
    push("rel_stat", 12, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk); rd(e.a, got);
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s a=%0d got=0x%0h exp=0x%0h", e.name, e.a, got, e.v); end
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    logic [31:0] got;
    bit fire;
    cyc(0, 1, 0, 32'd3);
    cyc(0, 1, 2, 32'h7);
    push("per_start_count", 1, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1 || exp_q.size() == 0) begin
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
      end
      fire = (k % 3 == 0);
      push("per_stat", 12, {31'b0, fire});
      push("per_irq", 16, {31'b0, fire});
      push("per_count", 1, fire ? 32'd3 : 32'(3 - (k % 3)));
      if (k == 1) begin
        e = exp_q.pop_front();
        @(negedge clk); rd(e.a, got);
        checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s a=%0d got=0x%0h exp=0x%0h", e.name, e.a, got, e.v); end
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        @(negedge clk); rd(e.a, got);
        checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", e.name, k, got, e.v); end
      end
      if (fire) begin
        cyc(0, 1, 12, 32'h1);
        push("per_clr_irq", 16, 32'h0);
        push("per_clr_stat", 12, 32'h0);
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          @(negedge clk); rd(e.a, got);
          checks++;
          if (got !== e.v) begin failures++; $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", e.name, k, got, e.v); end
        end
      end
    end
    cyc(0, 1, 2, 32'h0);
    cyc(1, 0, 0, 0);
    push("per_stop_ctrl", 2, 32'h0);
    push("per_stop_count", 1, 32'd3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk); rd(e.a, got);
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s a=%0d got=0x%0h exp=0x%0h", e.name, e.a, got, e.v); end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    logic [31:0] got;
    cyc(0, 1, 3, 32'd2);
    cyc(0, 1, 5, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 0, 0);
      push("os_stat", 12, (k == 2) ? 32'h2 : 32'h0);
      push("os_count", 4, (k == 1) ? 32'd1 : 32'd0);
      push("os_ctrl", 5, (k == 1) ? 32'h1 : 32'h0);
      push("os_irq", 16, 32'h0);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        @(negedge clk); rd(e.a, got);
        checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", e.name, k, got, e.v); end
      end
      if (k == 2) cyc(0, 1, 12, 32'h2);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    logic [31:0] got;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin
          cyc(0, 1, 6, 32'd5);
          cyc(0, 1, 8, 32'h1);
          cyc(0, 1, 7, 32'd1);
          cyc(1, 1, 12, 32'h4);
          push("sc_w1c_vs_expiry", 12, 32'h4);
          push("sc_expiry_count", 7, 32'd0);
          push("sc_expiry_ctrl", 8, 32'h0);
        end
        1: begin
          cyc(0, 1, 12, 32'h4);
          cyc(0, 1, 8, 32'h3);
          push("sc_start_count", 7, 32'd5);
        end
        2: begin
          cyc(1, 1, 7, 32'd7);
          push("sc_count_write_wins", 7, 32'd7);
        end
        default: begin
          cyc(1, 0, 0, 0);
          cyc(0, 1, 6, 32'd9);
          push("sc_reload_no_disturb", 7, 32'd6);
          push("sc_reload_value", 6, 32'd9);
          push("sc_stat_quiet", 12, 32'h0);
        end
      endcase
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        @(negedge clk); rd(e.a, got);
        checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, got, e.v); end
      end
    end
    cyc(0, 1, 8, 32'h0);
  endtask

  task automatic test_ie_off();
    exp_t e;
    logic [31:0] got;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin
          cyc(0, 1, 9, 32'd1);
          cyc(0, 1, 11, 32'h3);
          cyc(1, 0, 0, 0);
          push("ie0_stat", 12, 32'h8);
          push("ie0_pend", 13, 32'h0);
          push("ie0_irq", 16, 32'h0);
        end
        1: begin
          cyc(0, 1, 11, 32'h7);
          push("ie1_pend", 13, 32'h8);
          push("ie1_irq", 16, 32'h1);
        end
        2: begin
          cyc(0, 1, 12, 32'h8);
          cyc(0, 1, 9, 32'd0);
          cyc(0, 1, 11, 32'h7);
          repeat (5) cyc(1, 0, 0, 0);
          push("rl0_stat", 12, 32'h0);
          push("rl0_count", 10, 32'd0);
          push("rl0_irq", 16, 32'h0);
        end
        default: begin
          cyc(0, 1, 14, 32'hFFFF_FFFF);
          cyc(0, 1, 15, 32'hFFFF_FFFF);
          cyc(0, 1, 11, 32'h0);
          push("unmapped14", 14, 32'h0);
          push("unmapped15", 15, 32'h0);
          push("ie_ctrl3_off", 11, 32'h0);
        end
      endcase
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        @(negedge clk); rd(e.a, got);
        checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, got, e.v); end
      end
    end
  endtask

  task automatic test_cascade();
    exp_t e;
    logic [31:0] got;
    int fire_k;
`ifdef TICK_TIMER_CASCADE_EN
    fire_k = 6;
    push("casc_ctrl1", 5, 32'h9);
`else
    fire_k = 3;
    push("casc_ctrl1", 5, 32'h1);
`endif
    cyc(0, 1, 3, 32'd3);
    cyc(0, 1, 0, 32'd2);
    cyc(0, 1, 2, 32'hB);
    cyc(0, 1, 5, 32'h9);
    push("casc_ctrl0", 2, 32'h3);
    push("casc_count1", 4, 32'd3);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin
        cyc(1, 0, 0, 0);
        push("casc_stat", 12, ((k >= 2) ? 32'h1 : 32'h0) | ((k >= fire_k) ? 32'h2 : 32'h0));
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        @(negedge clk); rd(e.a, got);
        checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", e.name, k, got, e.v); end
      end
    end
    cyc(0, 1, 2, 32'h0);
    cyc(0, 1, 5, 32'h0);
    cyc(0, 1, 12, 32'hF);
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    logic [31:0] got;
    cyc(0, 1, 6, 32'h55);
    cyc(0, 1, 0, 32'd1);
    cyc(0, 1, 2, 32'h7);
    cyc(1, 0, 0, 0);
    push("pre_rst_irq", 16, 32'h1);
    push("pre_rst_stat", 12, 32'h1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk); rd(e.a, got);
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, got, e.v); end
    end
    @(posedge clk);
    #1 reset = 0;
    addr = 32'd12;
    push("rst_async_irq", 16, 32'h0);
    push("rst_async_stat", 12, 32'h0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({31'b0, irq} !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, irq, e.v); end
    e = exp_q.pop_front();
    checks++;
    if (dout !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, dout, e.v); end
    push("rst_reload0", 0, 32'h0);
    push("rst_ctrl0", 2, 32'h0);
    push("rst_reload2", 6, 32'h0);
    push("rst_count0", 1, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk); rd(e.a, got);
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, got, e.v); end
    end
    @(negedge clk); reset = 1;
    repeat (3) cyc(1, 0, 0, 0);
    push("post_rst_irq", 16, 32'h0);
    push("post_rst_stat", 12, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge clk); rd(e.a, got);
      checks++;
      if (got !== e.v) begin failures++; $display("FAIL %s got=0x%0h exp=0x%0h", e.name, got, e.v); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clk = 0; reset = 0; tick = 0; cs = 0; wen = 0; addr = 0; din = 0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_same_cycle();
    test_ie_off();
    test_cascade();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
